// File: rtl/tok_pkg.sv
// Token definitions shared by the lexer and the token printer: kind codes,
// keyword byte tables and their lengths, and the printer's internal enums.
`timescale 1ns/1ps
package tok_pkg;

  // Kind codes carried in token bits [15:8]
  localparam logic [7:0] KIND_NUM   = 8'd0;
  localparam logic [7:0] KIND_CHAR  = 8'd1;
  localparam logic [7:0] KIND_FOR   = 8'd2;
  localparam logic [7:0] KIND_WHILE = 8'd3;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // Keyword text lengths in bytes (unknown kinds render as one error byte)
  localparam logic [2:0] LEN_CHAR  = 3'd4;
  localparam logic [2:0] LEN_FOR   = 3'd3;
  localparam logic [2:0] LEN_WHILE = 3'd5;
  localparam logic [2:0] LEN_ERR   = 3'd1;

  // Collapsed token class; everything from kind 4 upward is CLS_ERR
  typedef enum logic [2:0] {
    CLS_NUM   = 3'd0,
    CLS_CHAR  = 3'd1,
    CLS_FOR   = 3'd2,
    CLS_WHILE = 3'd3,
    CLS_ERR   = 3'd4
  } tok_cls_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_SEP  = 2'd2
  } pr_state_e;

  function automatic tok_cls_e classify(input logic [7:0] kind);
    case (kind)
      KIND_NUM:   classify = CLS_NUM;
      KIND_CHAR:  classify = CLS_CHAR;
      KIND_FOR:   classify = CLS_FOR;
      KIND_WHILE: classify = CLS_WHILE;
      default:    classify = CLS_ERR;
    endcase
  endfunction

  // Number of text bytes for a token; NUM length is its decimal digit count
  function automatic logic [2:0] tok_len(input tok_cls_e cls, input logic [1:0] ndig);
    case (cls)
      CLS_NUM:   tok_len = {1'b0, ndig};
      CLS_CHAR:  tok_len = LEN_CHAR;
      CLS_FOR:   tok_len = LEN_FOR;
      CLS_WHILE: tok_len = LEN_WHILE;
      default:   tok_len = LEN_ERR;
    endcase
  endfunction

  // Keyword byte tables, indexed by byte position within the keyword
  function automatic logic [7:0] kw_byte(input tok_cls_e cls, input logic [2:0] idx);
    kw_byte = 8'h00;
    case (cls)
      CLS_CHAR: begin
        case (idx)
          3'd0:    kw_byte = 8'h63;
          3'd1:    kw_byte = 8'h68;
          3'd2:    kw_byte = 8'h61;
          default: kw_byte = 8'h72;
        endcase
      end
      CLS_FOR: begin
        case (idx)
          3'd0:    kw_byte = 8'h66;
          3'd1:    kw_byte = 8'h6f;
          default: kw_byte = 8'h72;
        endcase
      end
      CLS_WHILE: begin
        case (idx)
          3'd0:    kw_byte = 8'h77;
          3'd1:    kw_byte = 8'h68;
          3'd2:    kw_byte = 8'h69;
          3'd3:    kw_byte = 8'h6c;
          default: kw_byte = 8'h65;
        endcase
      end
      default: kw_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/u8_to_dec.sv
// Combinational 8-bit to decimal split using compare-subtract (no divider),
// plus the number of significant digits for leading-zero suppression.
`timescale 1ns/1ps
module u8_to_dec (
  input  logic [7:0] val,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [1:0] ndig
);

  // Peel off hundreds, then repeatedly subtract ten; the remainder is the ones digit
  always_comb begin : split
    logic [7:0] rem;
    hund = 4'd0;
    tens = 4'd0;
    rem  = val;
    if (rem >= 8'd200) begin
      hund = 4'd2;
      rem  = rem - 8'd200;
    end else if (rem >= 8'd100) begin
      hund = 4'd1;
      rem  = rem - 8'd100;
    end
    for (int k = 0; k < 9; k++) begin
      if (rem >= 8'd10) begin
        rem  = rem - 8'd10;
        tens = tens + 4'd1;
      end
    end
    ones = rem[3:0];
    if (val >= 8'd100)     ndig = 2'd3;
    else if (val >= 8'd10) ndig = 2'd2;
    else                   ndig = 2'd1;
  end

endmodule

// File: rtl/token_printer.sv
// Renders 16-bit tokens {kind, value} back into ASCII: keyword text or the
// decimal value, followed by one separator byte. Valid/ready on both sides.
`timescale 1ns/1ps
module token_printer
  import tok_pkg::*;
#(
  parameter logic [7:0] SEP      = 8'h20,
  parameter logic [7:0] ERR_CHAR = 8'h3f
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_VALID,
  output logic        I_READY,
  input  logic [15:0] I_DATA,
  output logic        O_VALID,
  input  logic        O_READY,
  output logic [7:0]  O_DATA
);

  pr_state_e  state_q, state_d;
  tok_cls_e   cls_q, cls_d;
  logic [3:0] hund_q, hund_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [1:0] ndig_q, ndig_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] o_data_q, o_data_d;
  logic       o_valid_q, o_valid_d;

  // Digits of the incoming value, valid while the token is on I_DATA
  logic [3:0] in_hund, in_tens, in_ones;
  logic [1:0] in_ndig;
  tok_cls_e   in_cls;
  logic [2:0] len_q;

  u8_to_dec u_dec (
    .val  (I_DATA[7:0]),
    .hund (in_hund),
    .tens (in_tens),
    .ones (in_ones),
    .ndig (in_ndig)
  );

  assign in_cls  = classify(I_DATA[15:8]);
  assign len_q   = tok_len(cls_q, ndig_q);
  assign I_READY = (state_q == ST_IDLE) && !RST;
  assign O_VALID = o_valid_q;
  assign O_DATA  = o_data_q;

  // Byte at position idx of a token's text. For NUM the position is shifted
  // by the suppressed leading zeros so idx 0 is always the first printed digit.
  function automatic logic [7:0] text_byte(
    input tok_cls_e   cls,
    input logic [2:0] idx,
    input logic [3:0] h,
    input logic [3:0] t,
    input logic [3:0] o,
    input logic [1:0] nd
  );
    logic [2:0] pos;
    logic [3:0] dig;
    pos = idx + 3'd3 - {1'b0, nd};
    case (pos)
      3'd0:    dig = h;
      3'd1:    dig = t;
      default: dig = o;
    endcase
    case (cls)
      CLS_NUM: text_byte = ASCII_ZERO + {4'd0, dig};
      CLS_ERR: text_byte = ERR_CHAR;
      default: text_byte = kw_byte(cls, idx);
    endcase
  endfunction

  // Next-state and output-register logic for the IDLE/EMIT/SEP sequencer
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    hund_d    = hund_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    ndig_d    = ndig_q;
    idx_d     = idx_q;
    o_data_d  = o_data_q;
    o_valid_d = o_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (I_VALID) begin
          // First byte goes out on the accept edge; idx then points at byte 1
          cls_d     = in_cls;
          hund_d    = in_hund;
          tens_d    = in_tens;
          ones_d    = in_ones;
          ndig_d    = in_ndig;
          idx_d     = 3'd1;
          o_data_d  = text_byte(in_cls, 3'd0, in_hund, in_tens, in_ones, in_ndig);
          o_valid_d = 1'b1;
          state_d   = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (o_valid_q && O_READY) begin
          if (idx_q == len_q) begin
            o_data_d = SEP;
            state_d  = ST_SEP;
          end else begin
            o_data_d = text_byte(cls_q, idx_q, hund_q, tens_q, ones_q, ndig_q);
            idx_d    = idx_q + 3'd1;
          end
        end
      end
      ST_SEP: begin
        if (o_valid_q && O_READY) begin
          o_valid_d = 1'b0;
          idx_d     = 3'd0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        o_valid_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any token in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_NUM;
      hund_q    <= 4'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      ndig_q    <= 2'd0;
      idx_q     <= 3'd0;
      o_data_q  <= 8'h00;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      ndig_q    <= ndig_d;
      idx_q     <= idx_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
    end
  end

endmodule

// File: tb/tb_token_printer.sv
// Bench for token_printer: directed cases plus randomized tokens and sink
// back-pressure, checked against a string-based model of the expected text.
`timescale 1ns/1ps
module tb_token_printer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        I_VALID = 1'b0;
  logic        I_READY;
  logic [15:0] I_DATA = 16'h0000;
  logic        O_VALID;
  logic        O_READY = 1'b0;
  logic [7:0]  O_DATA;

  token_printer dut (
    .CLK     (CLK),
    .RST     (RST),
    .I_VALID (I_VALID),
    .I_READY (I_READY),
    .I_DATA  (I_DATA),
    .O_VALID (O_VALID),
    .O_READY (O_READY),
    .O_DATA  (O_DATA)
  );

  always #5 CLK = ~CLK;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         rdy_mode = 0;   // 0: always ready, 1: random, 2: never
  int         xfer_cnt = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: the token's text as a string, then one separator
  task automatic push_exp(input logic [15:0] tok);
    string s;
    case (tok[15:8])
      8'd0:    s = $sformatf("%0d", tok[7:0]);
      8'd1:    s = "char";
      8'd2:    s = "for";
      8'd3:    s = "while";
      default: s = "?";
    endcase
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h20);
  endtask

  // Sink driver and monitor: set O_READY for the coming edge, then score transfers
  always begin
    @(negedge CLK);
    case (rdy_mode)
      0:       O_READY = 1'b1;
      1:       O_READY = 1'($urandom_range(0, 1));
      default: O_READY = 1'b0;
    endcase
    if (RST) begin
      check("iready_in_rst", I_READY, 1'b0);
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_hold_data", O_DATA, data_prev);
        check("stall_hold_valid", O_VALID, 1'b1);
      end
      if (O_VALID) check("iready_busy", I_READY, 1'b0);
      if (O_VALID && O_READY) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", O_DATA, 32'hFFFF_FFFF);
        end else begin
          check("byte", O_DATA, exp_q.pop_front());
        end
        xfer_cnt++;
        $display("xfer %0d: byte %02h", xfer_cnt, O_DATA);
      end
      stall_prev = O_VALID && !O_READY;
      data_prev  = O_DATA;
    end
  end

  stall_stable: assert property (@(posedge CLK) (!RST && O_VALID && !O_READY) |=> (O_VALID && $stable(O_DATA)))
    else $error("FAIL stall_assert: O_DATA changed while stalled");

  time acc_t;

  task automatic send(input logic [15:0] tok);
    int waited = 0;
    @(negedge CLK);
    I_VALID = 1'b1;
    I_DATA  = tok;
    while (!I_READY && waited < 400) begin
      @(negedge CLK);
      waited++;
    end
    if (!I_READY) begin
      check("accept_timeout", {31'd0, I_READY}, 1);
      I_VALID = 1'b0;
    end else begin
      @(posedge CLK);
      push_exp(tok);
      acc_t = $time;
      $display("token %04h accepted", tok);
      #1;
      I_VALID = 1'b0;
      I_DATA  = 16'($urandom);   // must be ignored outside IDLE
    end
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || O_VALID) && waited < 1000) begin
      @(negedge CLK);
      waited++;
    end
    check("drain_left", exp_q.size(), 0);
    @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t_a;
    int  base;
    logic [15:0] tok;

    // Reset state
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_ovalid", O_VALID, 1'b0);
    check("rst_odata", O_DATA, 8'h00);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("idle_iready", I_READY, 1'b1);

    // FOR with sink always ready: bytes on consecutive cycles, IDLE after SEP
    rdy_mode = 0;
    send(16'h0200);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("for_cadence_valid", O_VALID, 1'b1);
    end
    @(negedge CLK);
    check("for_iready_after", I_READY, 1'b1);
    check("for_ovalid_after", O_VALID, 1'b0);
    drain();

    // NUM boundaries back-to-back: "255 0 7 100 "
    send(16'h00FF);
    t_a = acc_t;
    send(16'h0000);
    send(16'h0007);
    send(16'h0064);
    check("num_cadence_cycles", 32'((acc_t - t_a) / 10), 11);
    drain();

    // WHILE under random back-pressure
    rdy_mode = 1;
    send(16'h0300);
    drain();

    // Unknown kind and CHAR
    rdy_mode = 0;
    send(16'h09AB);
    send(16'h0100);
    drain();

    // Reset after two bytes of WHILE have transferred
    base = xfer_cnt;
    send(16'h0300);
    for (int k = 0; k < 50 && xfer_cnt < base + 2; k++) @(posedge CLK);
    check("rst_mid_xfers", xfer_cnt - base, 2);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    check("midrst_ovalid", O_VALID, 1'b0);
    check("midrst_odata", O_DATA, 8'h00);
    check("midrst_iready", I_READY, 1'b1);
    send(16'h0100);
    drain();

    // Token stream a lexer produces for "for 42 while\n"
    send(16'h0200);
    send(16'h002A);
    send(16'h0300);
    drain();

    // Randomized tokens, gaps and back-pressure
    for (int n = 0; n < 60; n++) begin
      rdy_mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
      case ($urandom_range(0, 5))
        0, 5:    tok = {8'd0, 8'($urandom)};
        1:       tok = {8'd1, 8'($urandom)};
        2:       tok = {8'd2, 8'($urandom)};
        3:       tok = {8'd3, 8'($urandom)};
        default: tok = {8'($urandom_range(4, 255)), 8'($urandom)};
      endcase
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      send(tok);
    end
    rdy_mode = 1;
    drain();
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/token_printer.md
Name: token_printer

Overview:
Converts the 16-bit token stream {kind[15:8], value[7:0]} back into an ASCII byte stream: the inverse of the lexer.
Each token is rendered as its keyword text, or as the decimal digits of its value for NUM, followed by one separator byte.
The block sits on the token bus and feeds a byte sink such as a UART TX or debug FIFO, so token streams can be echoed and checked.
Both sides use valid/ready handshakes.

Parameters:
SEP, 8'h20, separator byte emitted after every token.
ERR_CHAR, 8'h3f, byte emitted for an unknown token kind ('?').

Ports:
CLK  in  1  clock.
RST  in  1  reset; synchronous, active-high.
I_VALID  in  1  token available.
I_READY  out  1  block can accept a token this cycle.
I_DATA  in  16  token; [15:8] kind, [7:0] value.
O_VALID  out  1  O_DATA holds a valid byte.
O_READY  in  1  sink accepts a byte this cycle.
O_DATA  out  8  ASCII byte.

Behaviour:
- Reset (RST=1 at a posedge): state IDLE, O_VALID=0, O_DATA=8'h00, all digit/index registers 0. I_READY=0 while RST is high.
- Reset mid-token aborts the token. No further bytes of it are emitted.
- Kind encoding: 0 NUM, 1 CHAR "char", 2 FOR "for", 3 WHILE "while". Kinds 4..255 are unknown and render as ERR_CHAR.
- For keyword kinds the value byte is ignored.
- I_READY = (state==IDLE) && !RST. A token is accepted on a posedge with I_VALID && I_READY.
- States:
  - IDLE: on accept, latch the token and go to EMIT. Load the first byte into O_DATA and set O_VALID=1 on that same edge, so the first byte is visible the cycle after accept.
  - EMIT: hold O_DATA and O_VALID stable while O_READY=0. On O_VALID && O_READY, load the next byte. After the last text byte, load SEP and go to SEP.
  - SEP: on O_READY, O_VALID<=0 and go to IDLE.
- Throughput: a token with N text bytes occupies N+1 byte transfers plus 1 IDLE cycle. With O_READY held at 1 that is N+2 cycles per token.
- Keyword text byte sequences:
  - CHAR: 63 68 61 72.
  - FOR: 66 6f 72.
  - WHILE: 77 68 69 6c 65.
  - Unknown: a single ERR_CHAR.
- NUM rendering:
  - Value v in 0..255 is split at accept into hundreds (0..2), tens (0..9) and ones (0..9) by compare-subtract. No division.
  - Digit count: 3 if v>=100, 2 if v>=10, else 1. Leading zeros are suppressed; v=0 emits "0".
  - Each digit byte is 8'h30 + digit.
- I_VALID and I_DATA are ignored outside IDLE. The upstream must hold the token until it is accepted.
- O_DATA must not change while O_VALID && !O_READY. Verify with an assertion.
- A byte index register counts bytes within the token: 3 bits, max 5 text bytes.

Decomposition:
- Shared package tok_pkg:
  - kind constants NUM, CHAR, FOR, WHILE, shared with the lexer;
  - keyword byte tables and lengths;
  - ASCII_ZERO = 8'h30.
- One natural sub-module: u8_to_dec. It is combinational: 8-bit in; hundreds, tens and ones digits plus a 2-bit digit count out.
- The FSM and byte mux live in token_printer.

Test Plan:
- Token 16'h0200 with O_READY=1 -> bytes 66 6f 72 20 on consecutive cycles; I_READY high again on the cycle after 20.
- NUM tokens 16'h00FF, 16'h0000, 16'h0007, 16'h0064, sent back-to-back -> "255 0 7 100 ", i.e. 32 35 35 20 30 20 37 20 31 30 30 20.
- Token 16'h0300 with O_READY toggling pseudo-randomly -> sink sees exactly 77 68 69 6c 65 20; O_DATA stable whenever stalled; I_READY low throughout.
- Token 16'h09AB -> 3f 20; token 16'h0100 -> 63 68 61 72 20.
- Token 16'h0300, then RST pulsed after 77 and 68 are transferred -> O_VALID=0 the cycle after reset. Then token 16'h0100 -> 63 68 61 72 20, with no 69/6c/65 residue.
- Loopback: lexer fed "for 42 while\n" -> token_printer -> output "for 42 while ".
